// File: rtl/ram_dp_clr.sv
// -----------------------------------------------------------------------------
// ram_dp_clr
//   Simple dual-port synchronous RAM with a built-in clear engine.
//   Port A is read/write with active-low lane enables; port B is read-only.
//   Reads are registered (latency 1, or 2 with OUT_REG = 1). An idle read
//   cycle loads zero into the read register rather than holding old data.
//   The clear engine zeroes every word once, one word per cycle. It runs after
//   reset release (CLEAR_ON_RESET = 1) or when clr_req is seen while idle.
//   While the engine runs, port A writes are dropped and both ports read 0.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst_n    : asynchronous active-low reset (array contents are kept)
//   a_cs_n   : port A select, active low
//   a_oe_n   : port A read enable, active low
//   a_wr_n   : port A write enable, active low
//   a_be_n   : port A lane write enables, active low, one bit per lane
//   a_addr   : port A address
//   a_din    : port A write data
//   a_q      : port A read data
//   b_cs_n   : port B select, active low
//   b_oe_n   : port B read enable, active low
//   b_addr   : port B address
//   b_q      : port B read data
//   clr_req  : one-cycle pulse that starts a clear
//   busy     : clear engine active
// -----------------------------------------------------------------------------
module ram_dp_clr #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int LANES          = 1,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_cs_n,
  input  logic                  a_oe_n,
  input  logic                  a_wr_n,
  input  logic [LANES-1:0]      a_be_n,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_q,
  input  logic                  b_cs_n,
  input  logic                  b_oe_n,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_q,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_W = DATA_WIDTH / LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    start_pend;  // deferred auto-clear after reset release

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_we;
  logic                    a_rd;
  logic                    b_rd;
  logic [DATA_WIDTH-1:0]   a_wr_word;
  logic [DATA_WIDTH-1:0]   a_rd_word;
  logic [DATA_WIDTH-1:0]   b_rd_word;
  logic [DATA_WIDTH-1:0]   a_s1;
  logic [DATA_WIDTH-1:0]   b_s1;

  assign busy = (state == CLEAR);

  // The clear engine owns the array while busy: user writes are dropped and
  // reads return zero.
  assign a_we = !a_cs_n && !a_wr_n && !busy;
  assign a_rd = !a_cs_n && !a_oe_n && !busy;
  assign b_rd = !b_cs_n && !b_oe_n && !busy;

  // Merged word as it will look after this edge's port A write; used only
  // for new-data read-during-write.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and infers a latch.
    a_wr_word = mem[a_addr];
    for (int l = 0; l < LANES; l++) begin
      if (!a_be_n[l]) a_wr_word[l*LANE_W +: LANE_W] = a_din[l*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
    if (RDW_MODE != 0 && a_we) begin
      a_rd_word = a_wr_word;
      if (b_addr == a_addr) b_rd_word = a_wr_word;
    end
  end

  // Clear FSM. The auto-clear is deferred by one edge through start_pend so
  // the FSM sits in IDLE (busy = 0) for as long as rst_n is held low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      start_pend <= (CLEAR_ON_RESET != 0);
    end else begin
      start_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req || start_pend) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array write port.
  // NOTE: the array has no reset; rst_n leaves contents intact and the clear
  // engine is the only way to zero it, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (a_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (!a_be_n[l]) mem[a_addr][l*LANE_W +: LANE_W] <= a_din[l*LANE_W +: LANE_W];
      end
    end
  end

  // First read stage: zero-filled when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= '0;
      b_s1 <= '0;
    end else begin
      a_s1 <= a_rd ? a_rd_word : '0;
      b_s1 <= b_rd ? b_rd_word : '0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] a_s2;
    logic [DATA_WIDTH-1:0] b_s2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_s2 <= '0;
        b_s2 <= '0;
      end else begin
        a_s2 <= a_s1;
        b_s2 <= b_s1;
      end
    end

    assign a_q = a_s2;
    assign b_q = b_s2;
  end else begin : g_no_out_reg
    assign a_q = a_s1;
    assign b_q = b_s1;
  end

endmodule
